// File: rtl/tx_mac_pad_fcs.sv
// Ethernet transmit MAC: preamble/SFD insertion, zero padding, CRC-32 FCS and
// inter-frame gap, paced by the PHY adapter's byte-slot enable.
module tx_mac_pad_fcs #(
  parameter int DATA_WIDTH      = 8,
  parameter int PREAMBLE_BYTES  = 7,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int PAD_EN          = 1,
  parameter int CRC_EN          = 1,
  parameter int IFG_BYTES       = 12,
  parameter int STAT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_tx_axis_tdata,
  input  logic                  s_tx_axis_tvalid,
  input  logic                  s_tx_axis_tlast,
  input  logic                  s_tx_axis_tuser,
  output logic                  s_tx_axis_trdy,
  input  logic                  rgmii_mac_tx_rdy,
  input  logic                  mii_select,
  output logic [DATA_WIDTH-1:0] rgmii_mac_tx_data,
  output logic                  rgmii_mac_tx_dv,
  output logic                  rgmii_mac_tx_er,
  output logic                  mii_mode,
  output logic [STAT_WIDTH-1:0] frame_cnt,
  output logic [STAT_WIDTH-1:0] err_cnt,
  output logic [2:0]            dbg_state
);

  localparam int               BC_W     = $clog2(MIN_FRAME_BYTES + 1);
  localparam logic [BC_W-1:0]  MIN_BC   = BC_W'(MIN_FRAME_BYTES);
  localparam logic [7:0]       PRE_LAST = 8'(PREAMBLE_BYTES - 1);
  localparam logic [7:0]       IFG_LAST = 8'(IFG_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_DRAIN, S_PAD, S_FCS, S_IFG
  } state_t;

  // Stream handshake: a byte transfers on a clock edge where tvalid and trdy
  // are both 1; trdy is only offered in PAYLOAD/DRAIN and only in a PHY slot.

  state_t                state, state_nxt, after_fill;
  logic [7:0]            slot_cnt;
  logic [BC_W-1:0]       byte_cnt, byte_cnt_inc;
  logic [31:0]           crc, fcs;
  logic                  bad, frame_bad, slot, start, ifg_entry;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  dv_nxt, er_nxt;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign slot           = rgmii_mac_tx_rdy;
  assign s_tx_axis_trdy = ((state == S_PAYLOAD) || (state == S_DRAIN)) && slot;
  assign byte_cnt_inc   = (byte_cnt == MIN_BC) ? byte_cnt : byte_cnt + BC_W'(1);
  assign after_fill     = (CRC_EN != 0) ? S_FCS : S_IFG;
  assign fcs            = ~crc;
  assign start          = slot && (state_nxt == S_PREAMBLE) && (state != S_PREAMBLE);
  assign ifg_entry      = slot && (state_nxt == S_IFG) && (state != S_IFG);
  // An error on the closing byte must still count the frame as bad.
  assign frame_bad      = bad || ((state == S_PAYLOAD) && (!s_tx_axis_tvalid || s_tx_axis_tuser));
  assign dbg_state      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (slot) begin
      case (state)
        S_IDLE:     if (s_tx_axis_tvalid) state_nxt = S_PREAMBLE;
        S_PREAMBLE: if (slot_cnt == PRE_LAST) state_nxt = S_SFD;
        S_SFD:      state_nxt = S_PAYLOAD;
        S_PAYLOAD: begin
          if (!s_tx_axis_tvalid) state_nxt = S_DRAIN;
          else if (s_tx_axis_tlast)
            state_nxt = ((PAD_EN != 0) && (byte_cnt_inc < MIN_BC)) ? S_PAD : after_fill;
        end
        S_DRAIN:    if (s_tx_axis_tvalid && s_tx_axis_tlast) state_nxt = S_IFG;
        S_PAD:      if (byte_cnt_inc == MIN_BC) state_nxt = after_fill;
        S_FCS:      if (slot_cnt == 8'd3) state_nxt = S_IFG;
        // A frame already waiting starts straight after the last gap slot.
        S_IFG:      if (slot_cnt == IFG_LAST)
                      state_nxt = s_tx_axis_tvalid ? S_PREAMBLE : S_IDLE;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_nxt = '0;
    dv_nxt   = 1'b0;
    er_nxt   = 1'b0;
    case (state)
      S_PREAMBLE: begin data_nxt = 8'h55; dv_nxt = 1'b1; end
      S_SFD:      begin data_nxt = 8'hD5; dv_nxt = 1'b1; end
      S_PAYLOAD: begin
        dv_nxt = 1'b1;
        if (s_tx_axis_tvalid) begin
          data_nxt = s_tx_axis_tdata;
          er_nxt   = s_tx_axis_tuser;
        end else begin
          er_nxt   = 1'b1;
        end
      end
      S_PAD:      dv_nxt = 1'b1;
      S_FCS: begin
        dv_nxt = 1'b1;
        case (slot_cnt[1:0])
          2'd0:    data_nxt = fcs[7:0];
          2'd1:    data_nxt = fcs[15:8];
          2'd2:    data_nxt = fcs[23:16];
          default: data_nxt = fcs[31:24];
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgmii_mac_tx_data <= '0;
      rgmii_mac_tx_dv   <= 1'b0;
      rgmii_mac_tx_er   <= 1'b0;
      mii_mode          <= 1'b0;
      frame_cnt         <= '0;
      err_cnt           <= '0;
      crc               <= 32'hFFFFFFFF;
      byte_cnt          <= '0;
      slot_cnt          <= '0;
      bad               <= 1'b0;
    end else if (slot) begin
      rgmii_mac_tx_data <= data_nxt;
      rgmii_mac_tx_dv   <= dv_nxt;
      rgmii_mac_tx_er   <= er_nxt;
      slot_cnt          <= (state_nxt != state) ? 8'd0 : slot_cnt + 8'd1;
      if (start) begin
        crc      <= 32'hFFFFFFFF;
        byte_cnt <= '0;
        bad      <= 1'b0;
        mii_mode <= mii_select;
      end else if ((state == S_PAYLOAD) && s_tx_axis_tvalid) begin
        crc      <= crc_next(crc, s_tx_axis_tdata);
        byte_cnt <= byte_cnt_inc;
        if (s_tx_axis_tuser) bad <= 1'b1;
      end else if (state == S_PAYLOAD) begin
        bad      <= 1'b1;
      end else if (state == S_PAD) begin
        crc      <= crc_next(crc, 8'h00);
        byte_cnt <= byte_cnt_inc;
      end
      if (ifg_entry) begin
        if (frame_bad) err_cnt   <= err_cnt + STAT_WIDTH'(1);
        else           frame_cnt <= frame_cnt + STAT_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/tx_mac_pad_fcs.md
Name: tx_mac_pad_fcs

Overview:
Parametrised next-generation Ethernet transmit MAC. It accepts frame payload (DA through end of data) on an 8-bit AXI-Stream slave and emits preamble, SFD, payload, optional zero padding, optional FCS and a configurable inter-frame gap toward the RGMII/MII adapter. The RGMII side paces it through rgmii_mac_tx_rdy; this supports both gigabit and 10/100 (mii_select) operation. It adds underrun detection, error propagation and frame/error statistics counters.

Parameters:
DATA_WIDTH, 8, stream and PHY-side byte width; only 8 is supported.
PREAMBLE_BYTES, 7, number of 0x55 bytes before the SFD (0xD5).
MIN_FRAME_BYTES, 60, minimum payload plus pad length before FCS.
PAD_EN, 1, when 1, short frames are zero-padded up to MIN_FRAME_BYTES.
CRC_EN, 1, when 1, the 4-byte FCS is appended.
IFG_BYTES, 12, idle byte-slots after each frame.
STAT_WIDTH, 16, width of the statistics counters.

Ports:
clk  in  1  system clock (125 MHz).
reset  in  1  asynchronous active-high reset.
s_tx_axis_tdata  in  DATA_WIDTH  payload byte.
s_tx_axis_tvalid  in  1  byte valid.
s_tx_axis_tlast  in  1  last payload byte of the frame.
s_tx_axis_tuser  in  1  upstream error flag on this byte.
s_tx_axis_trdy  out  1  MAC accepts the byte this cycle.
rgmii_mac_tx_rdy  in  1  byte slot enable; the MAC advances only when this is 1.
mii_select  in  1  10/100 mode flag; sampled in IDLE, held for the frame, and echoed on the mii_mode output.
rgmii_mac_tx_data  out  DATA_WIDTH  byte to PHY adapter.
rgmii_mac_tx_dv  out  1  data valid.
rgmii_mac_tx_er  out  1  transmit error.
mii_mode  out  1  mii_select as latched for the current frame.
frame_cnt  out  STAT_WIDTH  frames completed without error; wraps.
err_cnt  out  STAT_WIDTH  frames ended with underrun or tuser error; wraps.

Behaviour:
- Reset (async): state=IDLE. tx_data=0x00, tx_dv=0, tx_er=0, trdy=0, mii_mode=0, frame_cnt=0, err_cnt=0, CRC=0xFFFFFFFF, byte count=0.
- All outputs except s_tx_axis_trdy are registered. trdy is combinational: (state==PAYLOAD or DRAIN) and rgmii_mac_tx_rdy.
- A "slot" is a cycle with rgmii_mac_tx_rdy=1. State, counters and outputs change only in slots; otherwise they hold. No byte is duplicated or dropped when rdy toggles.
- State transitions:
  - IDLE -> PREAMBLE: on a slot with tvalid=1. Latch mii_select. Nothing is consumed.
  - PREAMBLE: emit 0x55 for PREAMBLE_BYTES slots with dv=1, then go to SFD.
  - SFD: emit 0xD5 for 1 slot, then go to PAYLOAD.
  - PAYLOAD: on a slot with tvalid, accept tdata and present it on the next edge with dv=1. Update the CRC and count++. tuser=1 sets tx_er=1 for that byte and marks the frame bad. On tlast, go to PAD if PAD_EN and count<MIN_FRAME_BYTES; else go to FCS if CRC_EN; else go to IFG.
  - Underrun: a PAYLOAD slot with tvalid=0 emits tx_er=1, dv=1, data 0x00. Mark the frame bad and go to DRAIN.
  - DRAIN: trdy=1 and dv=0. Discard bytes up to and including tlast, then go to IFG.
  - PAD: emit 0x00 (included in CRC) until count==MIN_FRAME_BYTES, then go to FCS or IFG.
  - FCS: emit ~CRC as 4 bytes, LSB byte first.
  - IFG: dv=0 for IFG_BYTES slots, then return to IDLE.
- CRC: CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, computed over payload and pad. The FCS of a good frame makes the receiver residue 0xDEBB20E3.
- Statistics: on IFG entry, frame_cnt++ if the frame is not bad, else err_cnt++. Both counters wrap modulo 2^STAT_WIDTH.
- Byte count saturates at MIN_FRAME_BYTES. Frames of any length are passed; jumbo frames are not truncated.
- Latency: first preamble byte on tx_data 1 slot after the IDLE tvalid slot. First payload byte 1 slot after SFD.
- Reset mid-frame: outputs go to reset values immediately. The partial frame is abandoned and no counter increments.

Test Plan:
- 1-byte payload 0xAB, rdy=1 -> 7×0x55, 0xD5, 0xAB, 59×0x00, 4 FCS bytes matching the software CRC-32, then 12 dv=0 cycles; frame_cnt=1.
- 64-byte payload 0x00..0x3F -> no pad, 64 data bytes plus FCS; receiver residue 0xDEBB20E3.
- Back-to-back frames with tvalid held high -> second preamble exactly 12 slots after the last FCS byte.
- tvalid dropped after 10 payload bytes -> tx_er=1 on byte 11, remaining input drained to tlast, err_cnt=1, frame_cnt unchanged.
- mii_select=1, rdy toggling 1/0 every cycle -> same byte sequence as the gigabit case with each byte held 2 cycles; mii_mode=1.
- tuser=1 on byte 5 -> tx_er=1 on that byte only, frame completes with FCS, err_cnt++; then reset asserted mid-preamble of the next frame -> dv=0 immediately and counters cleared.
